// File: rtl/ifetch_unit.sv
// ifetch_unit: pipeline fetch stage feeding the IF/ID register.
// Owns the PC, drives the icache request, and handles stalls, branch/jump
// redirects (including a redirect that arrives during an icache miss) and halt.
// Optional feature: define IFETCH_BTB_EN to add a direct-mapped branch target
// buffer that predicts next_pc in RUN; without it next_pc is always pc+4.
module ifetch_unit #(
    parameter logic [31:0] PC_RESET    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    input  logic        btb_wen,
    input  logic [31:0] btb_pc,
    input  logic [31:0] btb_target,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pcplusfour_out,
    output logic        fetch_valid,
    output logic        flush
);

    // RUN: normal fetch. DRAIN: waiting out a miss whose word will be dropped.
    // HALTED: fetch stopped until reset.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] pending_pc, pending_next;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic [31:0] redirect_aligned;

    assign pc_plus4         = pc + 32'd4;
    // Redirect targets are word aligned; low bits are dropped on capture.
    assign redirect_aligned = redirect_pc & ~32'h3;

    assign imemaddr       = pc;
    assign instr_out      = imemload;
    assign pc_out         = pc;
    assign pcplusfour_out = pc_plus4;

`ifdef IFETCH_BTB_EN
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]       btb_tag [BTB_ENTRIES];
    logic [31:0]            btb_tgt [BTB_ENTRIES];
    logic [IDX_W-1:0]       rd_idx, wr_idx;
    logic                   btb_hit;
    logic                   unused_bits;

    assign rd_idx      = pc[2 +: IDX_W];
    assign wr_idx      = btb_pc[2 +: IDX_W];
    assign btb_hit     = btb_valid[rd_idx] && (btb_tag[rd_idx] == pc[31 -: TAG_W]);
    assign next_pc     = btb_hit ? btb_tgt[rd_idx] : pc_plus4;
    assign unused_bits = ^btb_pc[1:0];

    // BTB valid bits: cleared on reset, set by an update.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            btb_valid <= '0;
        end else if (btb_wen) begin
            btb_valid[wr_idx] <= 1'b1;
        end
    end

    // BTB tag/target storage; a same-cycle lookup still sees the old entry.
    // NOTE: storage arrays are deliberately not reset; the valid bits alone
    // make stale contents harmless, and leaving them unreset keeps them RAM-able.
    always_ff @(posedge CLK) begin
        if (btb_wen) begin
            btb_tag[wr_idx] <= btb_pc[31 -: TAG_W];
            btb_tgt[wr_idx] <= btb_target;
        end
    end
`else
    logic unused_bits;

    assign next_pc     = pc_plus4;
    assign unused_bits = ^{btb_wen, btb_pc, btb_target};
`endif

    // State, PC and pending-redirect registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= RUN;
            pc         <= PC_RESET;
            pending_pc <= '0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            pending_pc <= pending_next;
        end
    end

    // Next-state, next-PC and handshake outputs.
    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a signal
        // unassigned and no latch is inferred.
        state_next   = state;
        pc_next      = pc;
        pending_next = pending_pc;
        imemREN      = 1'b1;
        fetch_valid  = 1'b0;
        flush        = 1'b0;

        case (state)
            RUN: begin
                if (halt) begin
                    state_next = HALTED;
                end else if (redirect) begin
                    flush = 1'b1;
                    if (ihit) begin
                        pc_next = redirect_aligned;
                    end else begin
                        // Keep pc on the missing address until the icache returns.
                        pending_next = redirect_aligned;
                        state_next   = DRAIN;
                    end
                end else begin
                    fetch_valid = ihit;
                    if (ihit && !stall) begin
                        pc_next = next_pc;
                    end
                end
            end

            DRAIN: begin
                if (halt) begin
                    state_next = HALTED;
                end else begin
                    if (redirect) begin
                        flush        = 1'b1;
                        pending_next = redirect_aligned;
                    end
                    if (ihit) begin
                        // Returned word is dropped; youngest redirect wins.
                        pc_next    = redirect ? redirect_aligned : pending_pc;
                        state_next = RUN;
                    end
                end
            end

            HALTED: begin
                imemREN = 1'b0;
            end

            default: begin
                state_next = RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: scenario tasks drive per-cycle stimulus rows; each row pushes
// its expected outputs onto a scoreboard queue, which is popped and compared
// once the combinational outputs have settled (2 time units after the falling
// edge, far from the rising edge). Build with +define+IFETCH_BTB_EN for the BTB.
module tb_ifetch_unit;

    localparam logic [31:0] PC_RESET = 32'h0000_0000;
`ifdef IFETCH_BTB_EN
    localparam logic [31:0] BTB_NEXT = 32'h0000_0400;
`else
    localparam logic [31:0] BTB_NEXT = 32'h0000_0084;
`endif

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ihit = 1'b0;
    logic [31:0] imemload = '0;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        btb_wen = 1'b0;
    logic [31:0] btb_pc = '0;
    logic [31:0] btb_target = '0;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pcplusfour_out;
    logic        fetch_valid;
    logic        flush;

    ifetch_unit #(.PC_RESET(PC_RESET), .BTB_ENTRIES(4)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
        .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .btb_wen(btb_wen), .btb_pc(btb_pc), .btb_target(btb_target),
        .instr_out(instr_out), .pc_out(pc_out), .pcplusfour_out(pcplusfour_out),
        .fetch_valid(fetch_valid), .flush(flush)
    );

    always #5 CLK = ~CLK;

    // Observable outputs packed for one-shot comparison.
    typedef struct packed {
        logic        ren;
        logic        valid;
        logic        flsh;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] p4;
        logic [31:0] instr;
    } obs_t;

    typedef struct {
        string name;
        obs_t  v;
    } exp_t;

    // One cycle of stimulus plus the outputs expected during that cycle.
    typedef struct {
        logic        nr;
        logic        ih;
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic        hl;
        logic [31:0] ea;
        logic        ev;
        logic        ef;
        logic        er;
    } row_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic obs_t observe();
        obs_t o;
        o.ren   = imemREN;
        o.valid = fetch_valid;
        o.flsh  = flush;
        o.addr  = imemaddr;
        o.pc    = pc_out;
        o.p4    = pcplusfour_out;
        o.instr = instr_out;
        return o;
    endfunction

    // Drive one row on the falling edge and push its expectation.
    task automatic apply(input row_t r, input string nm);
        logic [31:0] w;
        exp_t        e;
        @(negedge CLK);
        w           = $urandom();
        nRST        = r.nr;
        ihit        = r.ih;
        stall       = r.st;
        redirect    = r.rd;
        redirect_pc = r.rpc;
        halt        = r.hl;
        imemload    = w;
        e.name      = nm;
        e.v.ren     = r.er;
        e.v.valid   = r.ev;
        e.v.flsh    = r.ef;
        e.v.addr    = r.ea;
        e.v.pc      = r.ea;
        e.v.p4      = r.ea + 32'd4;
        e.v.instr   = w;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        row_t rows [2] = '{
            '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, PC_RESET, 1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, PC_RESET, 1'b0, 1'b0, 1'b1}
        };
        exp_t e;
        foreach (rows[i]) begin
            apply(rows[i], "reset");
            #2;
            e = sb.pop_front();
            n_cmp++;
            if (observe() !== e.v) begin
                n_err++;
                $display("FAIL %s[%0d]: got %h expected %h", e.name, i, observe(), e.v);
            end
        end
    endtask

    task automatic test_sequential();
        row_t rows [4] = '{
            '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h04, 1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h08, 1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0C, 1'b1, 1'b0, 1'b1}
        };
        exp_t e;
        foreach (rows[i]) begin
            apply(rows[i], "sequential");
            #2;
            e = sb.pop_front();
            n_cmp++;
            if (observe() !== e.v) begin
                n_err++;
                $display("FAIL %s[%0d]: got %h expected %h", e.name, i, observe(), e.v);
            end
        end
    endtask

    task automatic test_stall();
        row_t rows [7] = '{
            '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h10, 1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h10, 1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h10, 1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h10, 1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h14, 1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h18, 1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h1C, 1'b1, 1'b0, 1'b1}
        };
        exp_t e;
        foreach (rows[i]) begin
            apply(rows[i], "stall");
            #2;
            e = sb.pop_front();
            n_cmp++;
            if (observe() !== e.v) begin
                n_err++;
                $display("FAIL %s[%0d]: got %h expected %h", e.name, i, observe(), e.v);
            end
        end
    endtask

    task automatic test_redirect_hit();
        row_t rows [3] = '{
            '{1'b1, 1'b1, 1'b0, 1'b1, 32'h103, 1'b0, 32'h020, 1'b0, 1'b1, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b0, 32'h000, 1'b0, 32'h100, 1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b1, 32'h040, 1'b0, 32'h104, 1'b0, 1'b1, 1'b1}
        };
        exp_t e;
        foreach (rows[i]) begin
            apply(rows[i], "redirect_hit");
            #2;
            e = sb.pop_front();
            n_cmp++;
            if (observe() !== e.v) begin
                n_err++;
                $display("FAIL %s[%0d]: got %h expected %h", e.name, i, observe(), e.v);
            end
        end
    endtask

    // Redirect during a miss, then a second pair of redirects inside DRAIN
    // where the younger target must win.
    task automatic test_redirect_miss();
        row_t rows [11] = '{
            '{1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h040, 1'b0, 1'b1, 1'b1},
            '{1'b1, 1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 32'h040, 1'b0, 1'b0, 1'b1},
            '{1'b1, 1'b0, 1'b1, 1'b0, 32'h000, 1'b0, 32'h040, 1'b0, 1'b0, 1'b1},
            '{1'b1, 1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 32'h040, 1'b0, 1'b0, 1'b1},
            '{1'b1, 1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 32'h040, 1'b0, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b0, 32'h000, 1'b0, 32'h040, 1'b0, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b0, 32'h000, 1'b0, 32'h200, 1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 32'h204, 1'b0, 1'b1, 1'b1},
            '{1'b1, 1'b0, 1'b0, 1'b1, 32'h602, 1'b0, 32'h204, 1'b0, 1'b1, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b0, 32'h000, 1'b0, 32'h204, 1'b0, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b0, 32'h000, 1'b0, 32'h600, 1'b1, 1'b0, 1'b1}
        };
        exp_t e;
        foreach (rows[i]) begin
            apply(rows[i], "redirect_miss");
            #2;
            e = sb.pop_front();
            n_cmp++;
            if (observe() !== e.v) begin
                n_err++;
                $display("FAIL %s[%0d]: got %h expected %h", e.name, i, observe(), e.v);
            end
        end
    endtask

    // BTB entry for 0x80 -> 0x400 is written during the first row.
    task automatic test_btb();
        row_t rows [5] = '{
            '{1'b1, 1'b1, 1'b0, 1'b1, 32'h078, 1'b0, 32'h604, 1'b0, 1'b1, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b0, 32'h000, 1'b0, 32'h078, 1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b0, 32'h000, 1'b0, 32'h07C, 1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b0, 32'h000, 1'b0, 32'h080, 1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, BTB_NEXT, 1'b0, 1'b1, 1'b1}
        };
        exp_t e;
        foreach (rows[i]) begin
            apply(rows[i], "btb");
            btb_wen    = (i == 0);
            btb_pc     = 32'h80;
            btb_target = 32'h400;
            #2;
            e = sb.pop_front();
            n_cmp++;
            if (observe() !== e.v) begin
                n_err++;
                $display("FAIL %s[%0d]: got %h expected %h", e.name, i, observe(), e.v);
            end
        end
    endtask

    task automatic test_wrap();
        row_t rows [3] = '{
            '{1'b1, 1'b1, 1'b0, 1'b0, 32'h000, 1'b0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b0, 32'h000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b1, 32'h060, 1'b0, 32'h0000_0004, 1'b0, 1'b1, 1'b1}
        };
        exp_t e;
        foreach (rows[i]) begin
            apply(rows[i], "wrap");
            #2;
            e = sb.pop_front();
            n_cmp++;
            if (observe() !== e.v) begin
                n_err++;
                $display("FAIL %s[%0d]: got %h expected %h", e.name, i, observe(), e.v);
            end
        end
    endtask

    // Halt beats a same-cycle redirect, freezes fetch; reset restarts it.
    task automatic test_halt();
        row_t rows [7] = '{
            '{1'b1, 1'b1, 1'b0, 1'b1, 32'h300, 1'b1, 32'h060, 1'b0, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 32'h060, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b1, 1'b1, 32'h400, 1'b0, 32'h060, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b0, 32'h000, 1'b0, 32'h060, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 32'h000, 1'b0, PC_RESET, 1'b0, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b0, 32'h000, 1'b0, PC_RESET, 1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b0, 32'h000, 1'b0, PC_RESET + 32'd4, 1'b1, 1'b0, 1'b1}
        };
        exp_t e;
        foreach (rows[i]) begin
            apply(rows[i], "halt");
            #2;
            e = sb.pop_front();
            n_cmp++;
            if (observe() !== e.v) begin
                n_err++;
                $display("FAIL %s[%0d]: got %h expected %h", e.name, i, observe(), e.v);
            end
        end
    endtask

    // Reset while draining a redirect drops the pending target.
    task automatic test_reset_in_drain();
        row_t rows [4] = '{
            '{1'b1, 1'b0, 1'b0, 1'b1, 32'h700, 1'b0, PC_RESET + 32'd8, 1'b0, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 32'h000, 1'b0, PC_RESET, 1'b0, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b0, 32'h000, 1'b0, PC_RESET, 1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b0, 32'h000, 1'b0, PC_RESET + 32'd4, 1'b1, 1'b0, 1'b1}
        };
        exp_t e;
        foreach (rows[i]) begin
            apply(rows[i], "reset_in_drain");
            #2;
            e = sb.pop_front();
            n_cmp++;
            if (observe() !== e.v) begin
                n_err++;
                $display("FAIL %s[%0d]: got %h expected %h", e.name, i, observe(), e.v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_hit();
        test_redirect_miss();
        test_btb();
        test_wrap();
        test_halt();
        test_reset_in_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
